// File: rtl/msrv32_alu_op_issue.sv
// ALU operand/opcode issue stage for RV32I OP, OP-IMM, LUI and AUIPC with a 2-entry skid buffer.
// Optional perf counters (issue/stall) are enabled by defining MSRV32_ISSUE_PERF_CNT_EN.
module msrv32_alu_op_issue #(
    parameter int CNT_W = 32
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] rs1_in,
    input  logic [31:0] rs2_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] op_1_out,
    output logic [31:0] op_2_out,
    output logic [3:0]  opcode_out,
    output logic [4:0]  rd_addr_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        illegal_out
`ifdef MSRV32_ISSUE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] issue_cnt_out,
    output logic [CNT_W-1:0] stall_cnt_out
`endif
);

    if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt_w
        $error("CNT_W must be in 8..32");
    end

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
    } beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    state_t state_q, state_d;
    beat_t  out_q, out_d;
    beat_t  skid_q, skid_d;
    beat_t  dec;
    logic   dec_legal;
    logic   in_ready_q;
    logic   illegal_q;
    logic   in_fire, in_accept, out_fire;

    // Instruction decode
    always_comb begin
        logic [2:0] f3;
        logic       f7b5;
        f3        = instr_in[14:12];
        f7b5      = instr_in[30];
        dec       = '0;
        dec_legal = 1'b1;
        dec.rd    = instr_in[11:7];
        case (instr_in[6:0])
            OPC_OP: begin
                dec.op1 = rs1_in;
                dec.op2 = rs2_in;
                dec.opc = {f7b5 & ((f3 == 3'b000) | (f3 == 3'b101)), f3};
            end
            OPC_OP_IMM: begin
                dec.op1 = rs1_in;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.op2 = {27'b0, instr_in[24:20]};
                end else begin
                    dec.op2 = {{20{instr_in[31]}}, instr_in[31:20]};
                end
                dec.opc = {f7b5 & (f3 == 3'b101), f3};
            end
            OPC_LUI: begin
                dec.op2 = {instr_in[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                dec.op1 = pc_in;
                dec.op2 = {instr_in[31:12], 12'b0};
            end
            default: begin
                dec       = '0;
                dec_legal = 1'b0;
            end
        endcase
    end

    assign in_fire   = in_valid & in_ready_q;
    assign in_accept = in_fire & dec_legal;
    assign out_fire  = (state_q != ST_EMPTY) & out_ready;

    // Skid buffer next state; illegal instructions are consumed without occupying a slot
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_accept) begin
                    state_d = ST_ONE;
                    out_d   = dec;
                end
            end
            ST_ONE: begin
                if (in_accept && out_fire) begin
                    out_d = dec;
                end else if (in_accept) begin
                    state_d = ST_FULL;
                    skid_d  = dec;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q    <= ST_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != ST_FULL);
            illegal_q  <= in_fire & ~dec_legal;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign op_1_out    = out_q.op1;
    assign op_2_out    = out_q.op2;
    assign opcode_out  = out_q.opc;
    assign rd_addr_out = out_q.rd;
    assign illegal_out = illegal_q;

`ifdef MSRV32_ISSUE_PERF_CNT_EN
    logic [CNT_W-1:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_fire) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
            end
            if (out_valid && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign issue_cnt_out = issue_cnt_q;
    assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_msrv32_alu_op_issue.sv
// Self-checking bench for msrv32_alu_op_issue: directed vectors plus randomized traffic
// checked against a queue-based reference model.
module tb_msrv32_alu_op_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, rs1, rs2;
    logic        in_valid, out_ready;
    logic        in_ready, out_valid, illegal;
    logic [31:0] op1, op2;
    logic [3:0]  opcode;
    logic [4:0]  rd;
`ifdef MSRV32_ISSUE_PERF_CNT_EN
    logic [31:0] issue_cnt, stall_cnt;
    logic [31:0] exp_issue, exp_stall;
`endif

    msrv32_alu_op_issue #(.CNT_W(32)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .instr_in             (instr),
        .pc_in                (pc),
        .rs1_in               (rs1),
        .rs2_in               (rs2),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .op_1_out             (op1),
        .op_2_out             (op2),
        .opcode_out           (opcode),
        .rd_addr_out          (rd),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .illegal_out          (illegal)
`ifdef MSRV32_ISSUE_PERF_CNT_EN
        ,
        .issue_cnt_out        (issue_cnt),
        .stall_cnt_out        (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
    } beat_t;

    beat_t exp_q[$];
    logic  exp_ill;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_beats  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference decode, written straight from the instruction-set rules
    function automatic bit ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output beat_t bt);
        int          f3;
        bit          alt;
        int          simm;
        logic [31:0] upper;
        f3    = int'(ins[14:12]);
        alt   = ins[30];
        simm  = $signed(ins[31:20]);
        upper = ins & 32'hFFFF_F000;
        bt.rd = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                bt.op1 = a; bt.op2 = b;
                bt.opc = 4'(f3 + ((alt && (f3 == 0 || f3 == 5)) ? 8 : 0));
            end
            7'h13: begin
                bt.op1 = a;
                bt.op2 = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : 32'(simm);
                bt.opc = 4'(f3 + ((alt && f3 == 5) ? 8 : 0));
            end
            7'h37: begin bt.op1 = 0; bt.op2 = upper; bt.opc = 0; end
            7'h17: begin bt.op1 = p; bt.op2 = upper; bt.opc = 0; end
            default: begin bt.op1 = 0; bt.op2 = 0; bt.opc = 0; return 1'b0; end
        endcase
        return 1'b1;
    endfunction

    task automatic check_outputs();
        check_val("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check_val("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        check_val("illegal", 32'(illegal), 32'(exp_ill));
        if (exp_q.size() != 0) begin
            check_val("op1", op1, exp_q[0].op1);
            check_val("op2", op2, exp_q[0].op2);
            check_val("opcode", 32'(opcode), 32'(exp_q[0].opc));
            check_val("rd", 32'(rd), 32'(exp_q[0].rd));
        end
`ifdef MSRV32_ISSUE_PERF_CNT_EN
        check_val("issue_cnt", issue_cnt, exp_issue);
        check_val("stall_cnt", stall_cnt, exp_stall);
`endif
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check at the next fall
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic ordy);
        beat_t bt;
        bit    legal, in_fire;
        in_valid = v; instr = ins; pc = p; rs1 = a; rs2 = b; out_ready = ordy;
        legal   = ref_decode(ins, p, a, b, bt);
        in_fire = v && (exp_q.size() < 2);
`ifdef MSRV32_ISSUE_PERF_CNT_EN
        if (exp_q.size() != 0 && ordy) exp_issue++;
        if (exp_q.size() != 0 && !ordy) exp_stall++;
`endif
        if (exp_q.size() != 0 && ordy) begin
            $display("beat %0d out: op1=%08h op2=%08h opc=%h rd=%0d",
                     n_beats, exp_q[0].op1, exp_q[0].op2, exp_q[0].opc, exp_q[0].rd);
            n_beats++;
            void'(exp_q.pop_front());
        end
        if (in_fire && legal) exp_q.push_back(bt);
        if (in_fire && !legal) $display("illegal accepted: instr=%08h", ins);
        exp_ill = in_fire && !legal;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_ill = 1'b0;
`ifdef MSRV32_ISSUE_PERF_CNT_EN
        exp_issue = 0; exp_stall = 0;
`endif
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ill_opcodes [4];
        ill_opcodes[0] = 7'b0000011; ill_opcodes[1] = 7'b0100011;
        ill_opcodes[2] = 7'b1100011; ill_opcodes[3] = 7'b1101111;
        w = $urandom;
        case ($urandom_range(5))
            0: w[6:0] = 7'h33;
            1, 2: w[6:0] = 7'h13;
            3: w[6:0] = 7'h37;
            4: w[6:0] = 7'h17;
            default: w[6:0] = ill_opcodes[$urandom_range(3)];
        endcase
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 0; out_ready = 0; instr = 0; pc = 0; rs1 = 0; rs2 = 0;
        exp_ill = 1'b0;
`ifdef MSRV32_ISSUE_PERF_CNT_EN
        exp_issue = 0; exp_stall = 0;
`endif
        @(posedge clk); @(negedge clk);
        check_val("rst op1", op1, 32'h0);
        check_val("rst op2", op2, 32'h0);
        check_val("rst opcode", 32'(opcode), 32'h0);
        check_val("rst rd", 32'(rd), 32'h0);
        apply_reset();
        check_outputs();

        // Directed vectors with hard-coded expectations
        cycle(1, 32'h002081B3, 0, 5, 7, 1);
        check_val("add op1", op1, 32'd5);
        check_val("add op2", op2, 32'd7);
        check_val("add opc", 32'(opcode), 32'h0);
        check_val("add rd", 32'(rd), 32'd3);
        cycle(1, 32'h402081B3, 0, 5, 7, 1);
        check_val("sub opc", 32'(opcode), 32'h8);
        cycle(1, 32'h4040D193, 0, 9, 0, 1);
        check_val("srai op2", op2, 32'd4);
        check_val("srai opc", 32'(opcode), 32'hD);
        cycle(1, 32'hFFF00093, 0, 0, 0, 1);
        check_val("addi op2", op2, 32'hFFFF_FFFF);
        cycle(1, 32'h123452B7, 0, 3, 3, 1);
        check_val("lui op1", op1, 32'h0);
        check_val("lui op2", op2, 32'h1234_5000);
        cycle(1, 32'h12345297, 32'h100, 3, 3, 1);
        check_val("auipc op1", op1, 32'h100);
        check_val("auipc op2", op2, 32'h1234_5000);
        cycle(0, 0, 0, 0, 0, 1);

        // Back-pressure: three ADDIs with the consumer stalled
        cycle(1, 32'h00100093, 0, 1, 0, 0);
        cycle(1, 32'h00200093, 0, 2, 0, 0);
        cycle(1, 32'h00300093, 0, 3, 0, 0);
        check_val("bp in_ready", 32'(in_ready), 32'h0);
        check_val("bp hold op2", op2, 32'd1);
        cycle(1, 32'h00300093, 0, 3, 0, 1);
        cycle(1, 32'h00300093, 0, 3, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Illegal load then a normal ADD
        cycle(1, 32'h0000A083, 0, 0, 0, 1);
        check_val("load ill", 32'(illegal), 32'h1);
        check_val("load nv", 32'(out_valid), 32'h0);
        cycle(1, 32'h002081B3, 0, 11, 22, 1);
        check_val("post-ill op2", op2, 32'd22);

        // Reset while FULL
        cycle(1, 32'h00100093, 0, 1, 0, 0);
        cycle(1, 32'h00200093, 0, 2, 0, 0);
        apply_reset();
        check_val("rstfull ov", 32'(out_valid), 32'h0);
        check_val("rstfull ir", 32'(in_ready), 32'h1);
        check_outputs();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(99) < 70, rand_instr(), $urandom, $urandom, $urandom,
                  $urandom_range(99) < 60);
            if (i == 400) begin
                apply_reset();
                check_outputs();
            end
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
